// File: rtl/prn_reclaim_queue.sv
`default_nettype none
// ============================================================================
// Module   : prn_reclaim_queue
// Purpose  : In-order retirement tracker. Each renamed instruction gets an
//            entry that holds the physical registers it overwrote. Functional
//            units mark entries done out of order. Entries retire strictly in
//            program order, one per edge. A retirement returns the overwritten
//            PRNs to the rename free list.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            alloc_valid/_prn_valid/_prn - new entry from rename
//            alloc_ready, alloc_tag      - accept flag and the tag it receives
//            complete_valid/_tag         - per-FU completion notices
//            free_valid, free_prns       - registered PRN return pulse
//            retire_valid, retire_tag    - registered retirement pulse
//            count                       - occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module prn_reclaim_queue #(
  parameter int PRN_BITS     = 6,
  parameter int FU_COUNT     = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 16,
  parameter int TAG_BITS     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic                alloc_prn_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0] alloc_prn       [MAX_OPERANDS],
  output logic                alloc_ready,
  output logic [TAG_BITS-1:0] alloc_tag,
  input  logic                complete_valid  [FU_COUNT],
  input  logic [TAG_BITS-1:0] complete_tag    [FU_COUNT],
  output logic                free_valid      [MAX_OPERANDS],
  output logic [PRN_BITS-1:0] free_prns       [MAX_OPERANDS],
  output logic                retire_valid,
  output logic [TAG_BITS-1:0] retire_tag,
  output logic [TAG_BITS:0]   count
);

  localparam logic [TAG_BITS:0]   c_full_count = (TAG_BITS+1)'(DEPTH);
  localparam logic [TAG_BITS:0]   c_count_one  = (TAG_BITS+1)'(1);
  localparam logic [TAG_BITS-1:0] c_ptr_one    = TAG_BITS'(1);

  // Per-entry control state (reset) and PRN payload (not reset; only read
  // for an entry that is busy, which requires it to have been written).
  logic                r_busy      [DEPTH];
  logic                r_done      [DEPTH];
  logic                r_prn_valid [DEPTH][MAX_OPERANDS];
  logic [PRN_BITS-1:0] r_prn       [DEPTH][MAX_OPERANDS];
  logic [TAG_BITS-1:0] r_head;
  logic [TAG_BITS-1:0] r_tail;

  logic                w_accept;
  logic                w_retire;
  logic                w_hit [DEPTH];

  // Ready depends on registered count only, so a full queue refuses a new
  // entry even on the edge where the head retires.
  assign alloc_ready = (count != c_full_count);
  assign alloc_tag   = r_tail;
  assign w_accept    = alloc_valid && alloc_ready;
  assign w_retire    = r_busy[r_head] && r_done[r_head];

  // Any port naming an entry is a hit; several ports on one tag just merge.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_hit[e] = 1'b0;
      for (int p = 0; p < FU_COUNT; p++) begin
        if (complete_valid[p] && (complete_tag[p] == TAG_BITS'(e))) begin
          w_hit[e] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_busy[e] <= 1'b0;
        r_done[e] <= 1'b0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      count        <= '0;
      retire_valid <= 1'b0;
      retire_tag   <= '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        free_valid[i] <= 1'b0;
        free_prns[i]  <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_accept && (r_tail == TAG_BITS'(e))) begin
          // The tail is never busy when accepted, so a completion naming it
          // on this edge is stale and the fresh entry starts not done.
          r_busy[e] <= 1'b1;
          r_done[e] <= 1'b0;
        end else begin
          if (w_retire && (r_head == TAG_BITS'(e))) begin
            r_busy[e] <= 1'b0;
          end
          if (r_busy[e] && w_hit[e]) begin
            r_done[e] <= 1'b1;
          end
        end
      end

      if (w_accept) begin
        r_tail <= r_tail + c_ptr_one;
      end

      if (w_retire) begin
        r_head       <= r_head + c_ptr_one;
        retire_valid <= 1'b1;
        retire_tag   <= r_head;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          free_valid[i] <= r_prn_valid[r_head][i];
          free_prns[i]  <= r_prn[r_head][i];
        end
      end else begin
        retire_valid <= 1'b0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          free_valid[i] <= 1'b0;
        end
      end

      case ({w_accept, w_retire})
        2'b10:   count <= count + c_count_one;
        2'b01:   count <= count - c_count_one;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        r_prn_valid[r_tail][i] <= alloc_prn_valid[i];
        r_prn[r_tail][i]       <= alloc_prn[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prn_reclaim_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_prn_reclaim_queue
// Purpose  : Self-checking bench for prn_reclaim_queue. A program-order queue
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prn_reclaim_queue;

  localparam int PRN_BITS     = 6;
  localparam int FU_COUNT     = 4;
  localparam int MAX_OPERANDS = 3;
  localparam int DEPTH        = 16;
  localparam int TAG_BITS     = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                alloc_valid;
  logic                alloc_prn_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0] alloc_prn       [MAX_OPERANDS];
  logic                alloc_ready;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                complete_valid  [FU_COUNT];
  logic [TAG_BITS-1:0] complete_tag    [FU_COUNT];
  logic                free_valid      [MAX_OPERANDS];
  logic [PRN_BITS-1:0] free_prns       [MAX_OPERANDS];
  logic                retire_valid;
  logic [TAG_BITS-1:0] retire_tag;
  logic [TAG_BITS:0]   count;

  prn_reclaim_queue #(
    .PRN_BITS(PRN_BITS), .FU_COUNT(FU_COUNT), .MAX_OPERANDS(MAX_OPERANDS),
    .DEPTH(DEPTH), .TAG_BITS(TAG_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_prn_valid(alloc_prn_valid),
    .alloc_prn(alloc_prn), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .free_valid(free_valid), .free_prns(free_prns),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model: entries kept in program order ----------------
  typedef struct packed {
    logic [TAG_BITS-1:0]                  tag;
    logic [MAX_OPERANDS-1:0]              pv;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
    logic                                 done;
  } ent_t;

  ent_t                q[$];
  ent_t                m_e;
  bit                  m_ret;
  bit                  m_acc;
  logic [TAG_BITS-1:0] m_tail = '0;
  logic                m_fv [MAX_OPERANDS] = '{default: 1'b0};
  logic [PRN_BITS-1:0] m_fp [MAX_OPERANDS] = '{default: '0};
  logic                m_rv = 1'b0;
  logic [TAG_BITS-1:0] m_rt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_tail = '0;
      m_rv   = 1'b0;
      m_rt   = '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        m_fv[i] = 1'b0;
        m_fp[i] = '0;
      end
    end else begin
      m_ret = (q.size() > 0) && q[0].done;
      m_acc = alloc_valid && (q.size() != DEPTH);
      for (int p = 0; p < FU_COUNT; p++) begin
        for (int i = 0; i < q.size(); i++) begin
          if (complete_valid[p] && q[i].tag == complete_tag[p]) begin
            m_e = q[i];
            m_e.done = 1'b1;
            q[i] = m_e;
          end
        end
      end
      if (m_ret) begin
        m_e  = q.pop_front();
        m_rv = 1'b1;
        m_rt = m_e.tag;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          m_fv[i] = m_e.pv[i];
          m_fp[i] = m_e.prn[i];
        end
      end else begin
        m_rv = 1'b0;
        for (int i = 0; i < MAX_OPERANDS; i++) m_fv[i] = 1'b0;
      end
      if (m_acc) begin
        m_e.tag  = m_tail;
        m_e.done = 1'b0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          m_e.pv[i]  = alloc_prn_valid[i];
          m_e.prn[i] = alloc_prn[i];
        end
        q.push_back(m_e);
        m_tail = m_tail + 4'd1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("alloc_ready", alloc_ready, (q.size() != DEPTH));
    chk("alloc_tag", alloc_tag, m_tail);
    chk("count", count, q.size());
    chk("retire_valid", retire_valid, m_rv);
    chk("retire_tag", retire_tag, m_rt);
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      chk("free_valid", free_valid[i], m_fv[i]);
      chk("free_prns", free_prns[i], m_fp[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      alloc_prn_valid[i] = 1'b0;
      alloc_prn[i]       = '0;
    end
    for (int p = 0; p < FU_COUNT; p++) begin
      complete_valid[p] = 1'b0;
      complete_tag[p]   = '0;
    end
  endtask

  task automatic set_alloc(input logic [2:0] pv, input int p0, input int p1,
                           input int p2);
    alloc_valid        = 1'b1;
    alloc_prn_valid[0] = pv[0];
    alloc_prn_valid[1] = pv[1];
    alloc_prn_valid[2] = pv[2];
    alloc_prn[0]       = 6'(p0);
    alloc_prn[1]       = 6'(p1);
    alloc_prn[2]       = 6'(p2);
  endtask

  task automatic complete(input int port, input int tag);
    complete_valid[port] = 1'b1;
    complete_tag[port]   = 4'(tag);
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);

    // Mid-run reset with five entries busy.
    for (int i = 0; i < 5; i++) begin
      set_alloc(3'b001, 20 + i, 0, 0);
      tick();
    end
    idle();
    chk("five_busy_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_ready", alloc_ready, 1);
    chk("midrst_free_valid", free_valid[0], 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_alloc(3'b001, 50, 0, 0);
    chk("midrst_next_tag", alloc_tag, 0);
    tick();
    idle();
    chk("midrst_alloc_count", count, 1);

    // Single instruction.
    do_reset();
    set_alloc(3'b101, 7, 0, 40);
    tick();
    idle();
    complete(0, 0);
    tick();
    idle();
    chk("single_no_early_retire", retire_valid, 0);
    tick();
    chk("single_fv0", free_valid[0], 1);
    chk("single_fv1", free_valid[1], 0);
    chk("single_fv2", free_valid[2], 1);
    chk("single_fp0", free_prns[0], 7);
    chk("single_fp2", free_prns[2], 40);
    chk("single_rv", retire_valid, 1);
    chk("single_rt", retire_tag, 0);
    tick();
    chk("single_pulse_end", retire_valid, 0);
    chk("single_fp0_hold", free_prns[0], 7);

    // Out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'b001, 10 + i, 0, 0);
      tick();
    end
    idle();
    for (int t = 2; t >= 0; t--) begin
      complete(0, t);
      tick();
      idle();
    end
    chk("ooo_wait_head", retire_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_rv", retire_valid, 1);
      chk("ooo_rt", retire_tag, i);
      chk("ooo_fp0", free_prns[0], 10 + i);
    end
    tick();
    chk("ooo_drained_rv", retire_valid, 0);
    chk("ooo_drained_count", count, 0);

    // Full queue and wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(3'b001, i, 0, 0);
      tick();
    end
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    chk("full_tag", alloc_tag, 0);
    tick();
    chk("full_refused_count", count, 16);
    complete(0, 0);
    tick();
    complete_valid[0] = 1'b0;
    chk("full_done_count", count, 16);
    tick();
    chk("full_retire_rv", retire_valid, 1);
    chk("full_retire_rt", retire_tag, 0);
    chk("full_retire_count", count, 15);
    chk("full_retire_ready", alloc_ready, 1);
    chk("full_wrap_tag", alloc_tag, 0);
    tick();
    idle();
    chk("full_refill_count", count, 16);
    chk("full_refill_ready", alloc_ready, 0);
    chk("full_refill_tag", alloc_tag, 1);

    // Simultaneous accept, retire and stale completion to the tail.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'b010, 0, 30 + i, 0);
      tick();
    end
    idle();
    complete(0, 0);
    tick();
    idle();
    set_alloc(3'b001, 60, 0, 0);
    complete(1, 3);
    tick();
    idle();
    chk("simul_count", count, 3);
    chk("simul_rv", retire_valid, 1);
    chk("simul_rt", retire_tag, 0);
    chk("simul_fp1", free_prns[1], 30);
    chk("simul_tag", alloc_tag, 4);
    complete(0, 1);
    complete(2, 2);
    tick();
    idle();
    tick();
    chk("simul_rt1", retire_tag, 1);
    tick();
    chk("simul_rt2", retire_tag, 2);
    chk("simul_count1", count, 1);
    tick();
    tick();
    chk("simul_tail_not_done", retire_valid, 0);
    chk("simul_tail_kept", count, 1);

    // Multi-port completion and completion to an unallocated tag.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(3'b100, 0, 0, i + 1);
      tick();
    end
    idle();
    complete(0, 5);
    complete(3, 5);
    complete(1, 9);
    tick();
    idle();
    chk("multi_count", count, 6);
    tick();
    chk("multi_head_wait", retire_valid, 0);
    for (int p = 0; p < 4; p++) complete(p, p);
    tick();
    idle();
    complete(0, 4);
    tick();
    idle();
    chk("multi_rt0", retire_tag, 0);
    chk("multi_fp2", free_prns[2], 1);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("multi_rt", retire_tag, i);
    end
    chk("multi_empty", count, 0);
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b000, 0, 0, 0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("multi_tag9_count", count, 4);
    chk("multi_tag9_no_retire", retire_valid, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prn_reclaim_queue.md
# prn_reclaim_queue

In-order retirement tracker that closes the PRN loop opened by rename. It records, per renamed instruction, the previous physical registers overwritten by that instruction, accepts out-of-order completion notices from the functional units, and retires entries strictly in program order. On retirement it returns the overwritten PRNs to the rename free list through the `free_valid` / `free_prns` inputs of the rename stage.

## Interface
Parameters:
- `PRN_BITS`, 6, physical register number width
- `FU_COUNT`, 4, number of completion ports (one per functional unit)
- `MAX_OPERANDS`, 3, maximum destination PRNs per instruction
- `DEPTH`, 16, number of in-flight entries; power of two, ≥2
- `TAG_BITS`, `$clog2(DEPTH)`, entry tag width (derived)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `alloc_valid`  in  1  rename produced a valid, non-stalled mapping this cycle
- `alloc_prn_valid[MAX_OPERANDS]`  in  1 each  slot holds an overwritten PRN (rename `mapping_inputs_valid`)
- `alloc_prn[MAX_OPERANDS]`  in  PRN_BITS each  overwritten PRN (rename `mapping_inputs_prn`)
- `alloc_ready`  out  1  queue can accept an entry this cycle
- `alloc_tag`  out  TAG_BITS  tag given to the entry accepted this cycle
- `complete_valid[FU_COUNT]`  in  1 each  FU finished an instruction
- `complete_tag[FU_COUNT]`  in  TAG_BITS each  tag of the finished instruction
- `free_valid[MAX_OPERANDS]`  out  1 each  PRN being returned to the free list
- `free_prns[MAX_OPERANDS]`  out  PRN_BITS each  returned PRN
- `retire_valid`  out  1  an entry retired on the previous edge
- `retire_tag`  out  TAG_BITS  tag of that entry
- `count`  out  TAG_BITS+1  occupied entries

## Operation
- Per-entry state: `busy`, `done`, `prn_valid[MAX_OPERANDS]`, `prn[MAX_OPERANDS]`. The queue also holds a `head` pointer, a `tail` pointer (TAG_BITS, wrap modulo DEPTH) and `count`.
- `alloc_ready = (count != DEPTH)`. This is combinational from registered `count` only. When `count == DEPTH`, allocation is refused even if a retirement happens on the same edge (no same-cycle slot reuse).
- `alloc_tag = tail`, always driven, and meaningful only on accept.
- Accept happens when `alloc_valid && alloc_ready`. Entry[tail] is then written with `busy=1`, `done=0` and the PRN slots, and `tail` increments.
  - Entries with all `alloc_prn_valid=0` are still allocated and retired (stores, branches).
- Completion: for each port with `complete_valid`, if entry[tag].busy (pre-edge state), set `done=1`.
  - Completion to a non-busy entry is ignored.
  - Duplicate completions, or several ports naming one tag, are harmless.
- Retirement: at most one entry per edge. If entry[head] is `busy && done` (pre-edge state), the queue:
  - clears `busy` and increments `head`;
  - registers `free_valid[i] = prn_valid[i]` and `free_prns[i] = prn[i]`;
  - registers `retire_valid=1` and `retire_tag=head`.
- Otherwise `free_valid` and `retire_valid` are registered 0. `free_prns` and `retire_tag` hold their last value.
- `count` next = `count` + accept − retire. Simultaneous accept and retire leaves it unchanged.
- Empty queue (`count==0`): head is not busy, so no retirement happens. Completions are ignored.
- Reset (async, any time, including mid-operation): all entries `busy=0`, `done=0`; `head=tail=0`; `count=0`; `free_valid=0`, `free_prns=0`, `retire_valid=0`, `retire_tag=0`. The combinational outputs follow: `alloc_ready=1`, `alloc_tag=0`. In-flight PRNs are discarded. The rename stage is reset together with this block.

## Timing
- Allocation: accepted at edge N. The entry is visible (busy) after N. `count` increments after N.
- Completion sampled at edge N sets `done` after N.
- Retirement decision at edge N+1 on the registered `done`. `free_*` and `retire_*` are valid for exactly the one cycle after N+1.
- Minimum latency from completion to free pulse: 1 edge. Back-to-back done entries retire one per cycle.
- Completion and retirement of the same entry cannot occur on the same edge. Completion arriving for the head on edge N retires it on edge N+1.
- Allocation writing entry[tail] while a completion names the same tag on that edge: the entry was not busy pre-edge, so the completion is dropped and the allocation result (`done=0`) stands.

## Test plan
- Reset then idle: `rst_n` low mid-run with 5 entries busy → immediately `count=0`, `alloc_ready=1`, `free_valid=0`; the next allocation gets `alloc_tag=0`.
- Single instruction: alloc slots {valid,7},{0,-},{valid,40}, tag 0; complete tag 0 at edge 3 → one cycle after edge 4: `free_valid={1,0,1}`, `free_prns[0]=7`, `free_prns[2]=40`, `retire_tag=0`.
- Out-of-order completion: alloc tags 0,1,2; complete tag 2, then 1, then 0 on consecutive edges → retirements of 0,1,2 on three consecutive edges, in order, after tag 0 completes.
- Full: 16 allocs without completion → `count=16`, `alloc_ready=0`. With `alloc_valid` held, complete tag 0 → retire tag 0, then `alloc_ready=1` the following cycle, and the next `alloc_tag=0` (wrap).
- Simultaneous events: with `count=3`, on one edge accept an alloc and retire the head → `count` stays 3. The same edge carries a completion for the non-busy tail tag → ignored, and the new entry has `done=0`.
- Multi-port completion: FU0 and FU3 both complete tag 5, FU1 completes an unallocated tag 9 → entry 5 done once, entry 9 unaffected and not retired.
